// File: rtl/shift_right_seq_pkg.sv
// Shared constants for the sequential right shifter: default sizes and the
// FSM state encodings. Encoding 2'd3 is illegal and recovers to IDLE.
package shift_right_seq_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter (logical or arithmetic), one bit per cycle.
// Handshake: Start is accepted only on a rising edge where the FSM is IDLE;
// operands are captured at that edge. Busy is high in every non-IDLE state,
// and Done is a one-cycle registered pulse during which ShiftOut holds the
// result. Start seen while Busy (including the Done cycle) is ignored.
module shift_right_seq
  import shift_right_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic               Arith,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   ShiftOut,
  output logic [1:0]         dbg_state
);

  state_t             state_q;
  state_t             state_d;
  logic [SHAMT_W-1:0] count_q;
  logic               fill_q;

  // State register; synchronous reset aborts any operation in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a zero shift amount skips straight to DONE so the
  // counter is never decremented from zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = (Shamt != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (count_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: capture operands on an accepted Start, then shift one bit per
  // cycle with the fill bit latched at capture; otherwise hold the result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ShiftOut <= '0;
      count_q  <= '0;
      fill_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            ShiftOut <= A;
            count_q  <= Shamt;
            fill_q   <= Arith & A[WIDTH-1];
          end
        end
        ST_SHIFT: begin
          ShiftOut <= {fill_q, ShiftOut[WIDTH-1:1]};
          count_q  <= count_q - SHAMT_W'(1);
        end
        default: begin
          ShiftOut <= ShiftOut;
        end
      endcase
    end
  end

  // Status outputs are pure decodes of the state register.
  always_comb begin
    Busy      = (state_q != ST_IDLE);
    Done      = (state_q == ST_DONE);
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_shift_right_seq.sv
// Bench for shift_right_seq: driver tasks push expected results into a
// queue when a request is issued; a monitor pops and compares on each Done.
module tb_shift_right_seq;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               Clk;
  logic               Reset;
  logic               Start;
  logic [WIDTH-1:0]   A;
  logic [SHAMT_W-1:0] Shamt;
  logic               Arith;
  logic               Busy;
  logic               Done;
  logic [WIDTH-1:0]   ShiftOut;
  logic [1:0]         dbg_state;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int done_seen  = 0;
  int issued     = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               exp_cyc_q[$];

  shift_right_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .A        (A),
    .Shamt    (Shamt),
    .Arith    (Arith),
    .Busy     (Busy),
    .Done     (Done),
    .ShiftOut (ShiftOut),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc = cyc + 1;

  // reference model: plain shift arithmetic on the captured operands
  function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] a,
                                                 input int sh, input logic ar);
    logic signed [WIDTH-1:0] sa;
    sa = a;
    if (ar) return sa >>> sh;
    return a >> sh;
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: called and returns at a negedge; waits for IDLE, pulses Start
  task automatic start_txn(input logic [WIDTH-1:0] a, input int sh, input logic ar);
    int n = 0;
    while (Busy && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("idle_wait_timeout", {31'd0, Busy}, 32'd0);
    exp_q.push_back(ref_shift(a, sh, ar));
    exp_cyc_q.push_back(cyc + 1 + sh);
    issued++;
    A     = a;
    Shamt = SHAMT_W'(sh);
    Arith = ar;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    A     = $urandom;
    Shamt = SHAMT_W'($urandom_range(0, 31));
    Arith = 1'($urandom_range(0, 1));
  endtask

  // driver: one-cycle Start pulse that the DUT is expected to ignore
  task automatic poke(input logic [WIDTH-1:0] a, input int sh, input logic ar);
    A     = a;
    Shamt = SHAMT_W'(sh);
    Arith = ar;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || Busy) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // monitor / scoreboard
  always @(negedge Clk) begin
    if (!Reset && Done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got ShiftOut 0x%08h with no request outstanding (cycle %0d)",
                 ShiftOut, cyc);
      end else begin
        check("result", ShiftOut, exp_q.pop_front());
        check("latency_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        check("busy_with_done", {31'd0, Busy}, 32'd1);
      end
    end
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset with Start held high: nothing may be captured
    Reset = 1'b1;
    Start = 1'b1;
    A     = 32'hDEADBEEF;
    Shamt = 5'd3;
    Arith = 1'b1;
    repeat (2) @(negedge Clk);
    check("reset_shiftout", ShiftOut, 32'h0);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_done", {31'd0, Done}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    Reset = 1'b0;
    Start = 1'b0;
    @(negedge Clk);

    // directed corner cases
    start_txn(32'h80000000, 4, 1'b0);
    start_txn(32'h80000000, 4, 1'b1);
    start_txn(32'h12345678, 0, 1'b0);
    start_txn(32'hFFFFFFFF, 31, 1'b0);
    start_txn(32'hFFFFFFFF, 31, 1'b1);
    start_txn(32'hFFFFFFFF, 13, 1'b1);
    start_txn(32'h7FFFFFFF, 31, 1'b1);
    drain();

    // ignore while busy, then back-to-back acceptance the cycle after Done
    start_txn(32'h00000100, 8, 1'b0);
    @(negedge Clk);
    poke(32'hFFFFFFFF, 1, 1'b1);
    n = 0;
    while (!Done && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check("done_wait_timeout", {31'd0, Done}, 32'd1);
    poke(32'hFFFFFFFF, 1, 1'b1);
    check("idle_after_done", {31'd0, Busy}, 32'd0);
    start_txn(32'hA5A5A5A5, 3, 1'b1);
    drain();
    check("busy_test_done_count", 32'(done_seen), 32'(issued));

    // reset mid-operation aborts with no Done
    start_txn(32'hF0000000, 20, 1'b1);
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("midreset_shiftout", ShiftOut, 32'h0);
    check("midreset_busy", {31'd0, Busy}, 32'd0);
    check("midreset_done", {31'd0, Done}, 32'd0);
    check("midreset_state", {30'd0, dbg_state}, 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    issued--;
    Reset = 1'b0;
    @(negedge Clk);
    start_txn(32'h00000040, 2, 1'b0);
    drain();

    // randomized traffic with random idle gaps
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      start_txn(a, $urandom_range(0, 31), 1'($urandom_range(0, 1)));
    end
    drain();

    // result must hold while idle
    begin
      logic [WIDTH-1:0] held;
      held = ShiftOut;
      Start = 1'b0;
      A = $urandom;
      repeat (3) @(negedge Clk);
      check("idle_hold", ShiftOut, held);
    end

    check("total_done_count", 32'(done_seen), 32'(issued));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
